score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
Parametrised game-score unit for the helicopter game. It counts elapsed play time in BCD digits using an internal tick divider and a small game-state FSM (idle/run/pause/over). It keeps a high-score register and drives one active-low 7-segment pattern per digit. It sits between the game-control FSM (start, pause, collision) and the board HEX displays.

Parameters:
DIGITS, 4, number of BCD digits in the score (1..8)
TICK_DIV, 50000000, clkout cycles per score increment (>=2)

Ports:
clkout  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  level; starts a new game from IDLE or OVER
pause  input  1  level; holds the game while high in RUN/PAUSED
collision  input  1  level; ends the game
show_high  input  1  1 = displays show the high score, 0 = current score
score_bcd  output  4*DIGITS  current score; nibble i = digit i, LS digit in [3:0]
high_bcd  output  4*DIGITS  high score
state  output  2  00 IDLE, 01 RUN, 10 PAUSED, 11 OVER
new_high  output  1  one-cycle pulse when the high score is replaced
saturated  output  1  high while score_bcd is all 9s
seg  output  7*DIGITS  active-low segments; digit i at [7i+6:7i], bit order a..g from MSB to LSB

Behaviour:
- Reset is resetn, asynchronous, active-low, on clock clkout.
- Reset values: state=IDLE, score_bcd=0, high_bcd=0, divider=0, new_high=0, saturated=0.
- Outputs are registered, except seg, which is combinational from the selected BCD value.
- Divider: width $clog2(TICK_DIV). Counts 0..TICK_DIV-1 only in RUN.
  - tick = (count==TICK_DIV-1) in RUN; count then wraps to 0.
  - The divider is frozen in PAUSED, not cleared.
  - It is cleared on entry to RUN from IDLE/OVER.
- FSM transitions, priority listed highest first:
  - IDLE: start -> RUN. On this transition score_bcd and the divider are cleared.
  - RUN:
    - collision -> OVER.
    - else pause -> PAUSED.
    - else on tick, score increments.
    - start is ignored.
  - PAUSED:
    - collision -> OVER.
    - else !pause -> RUN, with the divider resuming from its held value.
  - OVER:
    - start -> RUN, clearing score and divider; the high score is retained.
    - Otherwise the score is held.
- Collision in the same cycle as a tick: no increment. The game ends with the pre-tick score.
- BCD increment: the LS digit adds 1; a digit at 9 wraps to 0 and carries to the next digit.
  - At all 9s the score saturates (stays at all 9s). saturated=1 and the FSM stays in RUN.
- High score: on the RUN/PAUSED -> OVER transition, if score_bcd > high_bcd (an unsigned compare of the packed nibbles):
  - high_bcd <= score_bcd on the next edge;
  - new_high pulses 1 for exactly that cycle.
  - An equal score does not update high_bcd.
- Display: seg encodes show_high ? high_bcd : score_bcd, one decoder per digit.
  - Patterns 0..9 are standard active-low.
  - Nibbles 10..15 cannot occur; they decode to all-off (7'b1111111).
- Reset mid-game: returns immediately to IDLE. high_bcd is lost (cleared).

Optional Feature:
SCORE_HIGH_EN
- Defined: high-score register, compare logic, new_high pulse and show_high selection are all built as described.
- Undefined: high_bcd ties to 0, new_high ties to 0, show_high is ignored, and seg always shows score_bcd. No compare or high-score flops are generated.

Decomposition:
- Shared package score_pkg holds:
  - state enum (IDLE, RUN, PAUSED, OVER) with 2-bit encodings;
  - the BCD nibble typedef;
  - the segment pattern constants for 0..9 and blank.
- One natural sub-module: bcd_7seg, a combinational nibble-to-active-low-segment decoder, instantiated DIGITS times with a generate loop.
- The BCD incrementer stays inline in score_keeper.

Test Plan:
- Parameters DIGITS=2, TICK_DIV=4. Reset, then start for 1 cycle -> state=01; score_bcd=0x01 after 4 cycles, 0x02 after 8; seg[6:0]=7'b1001111 at score 0x01.
- Score at 0x09, then a tick -> score_bcd=0x10 (carry). Preload or run to 0x99, then another tick -> stays 0x99, saturated=1, state=01.
- In RUN with divider count=2, pause held for 10 cycles -> state=10, score unchanged. Release pause -> next increment 2 cycles later (divider resumed, not restarted).
- Collision asserted in the same cycle as a tick at score 0x05 -> state=11, score_bcd=0x05; high_bcd=0x05 next cycle with a 1-cycle new_high pulse.
- Second game ending at 0x03 -> high_bcd stays 0x05 and new_high stays 0. Set show_high=1 -> seg shows 0x05 (digit0 7'b0100100).
- resetn pulsed low mid-RUN, asynchronous to clkout -> all outputs return to reset values immediately and state=00. With SCORE_HIGH_EN undefined, run the collision scenario -> high_bcd=0 and new_high=0 throughout.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: game states, BCD nibble
// type and active-low 7-segment patterns (bit order a..g, MSB = a).
package score_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        OVER   = 2'b11
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles blank the digit.
module bcd_7seg
    import score_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_keeper.sv
// Game score unit: tick divider, IDLE/RUN/PAUSED/OVER FSM, saturating BCD score,
// optional high-score register (SCORE_HIGH_EN) and per-digit 7-segment outputs.
module score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clkout,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  collision,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [1:0]            state,
    output logic                  new_high,
    output logic                  saturated,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [4*DIGITS-1:0]    score_q;
    logic                   sat_q;
    logic [4*DIGITS-1:0]    score_inc;
    logic                   carry;
    logic [4*DIGITS-1:0]    disp;

    function automatic logic all_nines(input logic [4*DIGITS-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    // Ripple BCD increment; all-9s holds instead of wrapping to zero.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        if (all_nines(score_q)) score_inc = score_q;
    end

    always_ff @(posedge clkout or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            score_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        score_q <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                RUN: begin
                    // Collision wins over a coincident tick: the pre-tick score stands.
                    if (collision) begin
                        state_q <= OVER;
                    end else if (pause) begin
                        state_q <= PAUSED;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        score_q <= score_inc;
                        sat_q   <= all_nines(score_inc);
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                PAUSED: begin
                    if (collision) begin
                        state_q <= OVER;
                    end else if (!pause) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SCORE_HIGH_EN
    logic [4*DIGITS-1:0] high_q;
    logic                new_high_q;
    logic                ends_game;

    assign ends_game = collision && ((state_q == RUN) || (state_q == PAUSED));

    always_ff @(posedge clkout or negedge resetn) begin
        if (!resetn) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            new_high_q <= 1'b0;
            if (ends_game && (score_q > high_q)) begin
                high_q     <= score_q;
                new_high_q <= 1'b1;
            end
        end
    end

    assign high_bcd = high_q;
    assign new_high = new_high_q;
    assign disp     = show_high ? high_q : score_q;
`else
    logic unused_show_high;

    assign unused_show_high = show_high;
    assign high_bcd         = '0;
    assign new_high         = 1'b0;
    assign disp             = score_q;
`endif

    assign score_bcd = score_q;
    assign state     = state_q;
    assign saturated = sat_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_7seg u_dec (
            .bcd_i (disp[4*g +: 4]),
            .seg_o (seg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper (DIGITS=2, TICK_DIV=4): directed table,
// hand-written corner sequences and random stimulus against an integer score model.
module tb_score_keeper;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int MAXSC    = 99;
`ifdef SCORE_HIGH_EN
    localparam int HE = 1;
`else
    localparam int HE = 0;
`endif

    logic                clkout = 1'b0;
    logic                resetn = 1'b0;
    logic                start = 1'b0, pause = 1'b0, collision = 1'b0, show_high = 1'b0;
    logic [4*DIGITS-1:0] score_bcd, high_bcd;
    logic [1:0]          state;
    logic                new_high, saturated;
    logic [7*DIGITS-1:0] seg;

    int tests = 0;
    int fails = 0;

    score_keeper #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clkout    (clkout),
        .resetn    (resetn),
        .start     (start),
        .pause     (pause),
        .collision (collision),
        .show_high (show_high),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .state     (state),
        .new_high  (new_high),
        .saturated (saturated),
        .seg       (seg)
    );

    always #5 clkout = ~clkout;

    // Reference model: plain integers for score, tick phase and high score.
    int m_state, m_score, m_cnt, m_high, m_newhigh;
    logic [6:0] seg_ref [10];

    function automatic logic [7:0] to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_cnt = 0; m_high = 0; m_newhigh = 0;
    endtask

    task automatic model_end_game();
        m_state = 3;
        if (HE == 1 && m_score > m_high) begin
            m_high    = m_score;
            m_newhigh = 1;
        end
    endtask

    task automatic model_step();
        m_newhigh = 0;
        case (m_state)
            0, 3: if (start) begin m_state = 1; m_score = 0; m_cnt = 0; end
            1: begin
                if (collision) model_end_game();
                else if (pause) m_state = 2;
                else begin
                    m_cnt = (m_cnt + 1) % TICK_DIV;
                    if (m_cnt == 0 && m_score < MAXSC) m_score++;
                end
            end
            default: begin
                if (collision) model_end_game();
                else if (!pause) m_state = 1;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int disp;
        disp = (HE == 1 && show_high) ? m_high : m_score;
        check("state", 32'(state), 32'(m_state));
        check("score", 32'(score_bcd), 32'(to_bcd(m_score)));
        check("high", 32'(high_bcd), 32'(to_bcd(m_high)));
        check("new_high", 32'(new_high), 32'(m_newhigh));
        check("saturated", 32'(saturated), 32'(m_score == MAXSC));
        check("seg", 32'(seg), 32'({seg_ref[(disp / 10) % 10], seg_ref[disp % 10]}));
    endtask

    task automatic cycle();
        @(posedge clkout);
        model_step();
        @(negedge clkout);
        check_all();
    endtask

    task automatic drive(input logic s, input logic p, input logic c);
        start = s; pause = p; collision = c;
    endtask

    typedef struct {
        logic       st, pa, co;
        logic [1:0] exp_state;
        logic [7:0] exp_score;
        logic [6:0] exp_seg0;
    } vec_t;
    vec_t tbl [24];

    task automatic set_vec(input int i, input logic s, input logic p, input logic [1:0] es,
                           input logic [7:0] esc, input logic [6:0] eseg);
        tbl[i].st = s; tbl[i].pa = p; tbl[i].co = 1'b0;
        tbl[i].exp_state = es; tbl[i].exp_score = esc; tbl[i].exp_seg0 = eseg;
    endtask

    initial begin
        bit seen_carry;
        seg_ref[0] = 7'b0000001; seg_ref[1] = 7'b1001111; seg_ref[2] = 7'b0010010;
        seg_ref[3] = 7'b0000110; seg_ref[4] = 7'b1001100; seg_ref[5] = 7'b0100100;
        seg_ref[6] = 7'b0100000; seg_ref[7] = 7'b0001111; seg_ref[8] = 7'b0000000;
        seg_ref[9] = 7'b0000100;

        // Start, tick every 4 cycles, then pause with divider at 2 and resume.
        set_vec(0, 1, 0, 2'b01, 8'h00, 7'b0000001);
        for (int i = 1; i < 4; i++) set_vec(i, 0, 0, 2'b01, 8'h00, 7'b0000001);
        for (int i = 4; i < 8; i++) set_vec(i, 0, 0, 2'b01, 8'h01, 7'b1001111);
        for (int i = 8; i < 11; i++) set_vec(i, 0, 0, 2'b01, 8'h02, 7'b0010010);
        for (int i = 11; i < 21; i++) set_vec(i, 0, 1, 2'b10, 8'h02, 7'b0010010);
        set_vec(21, 0, 0, 2'b01, 8'h02, 7'b0010010);
        set_vec(22, 0, 0, 2'b01, 8'h02, 7'b0010010);
        set_vec(23, 0, 0, 2'b01, 8'h03, 7'b0000110);

        model_reset();
        #12;
        check_all();
        @(negedge clkout);
        resetn = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].st, tbl[i].pa, tbl[i].co);
            cycle();
            check("tbl_state", 32'(state), 32'(tbl[i].exp_state));
            check("tbl_score", 32'(score_bcd), 32'(tbl[i].exp_score));
            check("tbl_seg0", 32'(seg[6:0]), 32'(tbl[i].exp_seg0));
        end
        drive(0, 0, 0);

        // Run on to carry and saturation.
        seen_carry = 0;
        for (int k = 0; k < 1000 && m_score < MAXSC; k++) begin
            cycle();
            if (!seen_carry && m_score == 10) begin
                seen_carry = 1;
                check("carry_09_10", 32'(score_bcd), 32'h10);
            end
        end
        check("reach_sat", 32'(m_score), MAXSC);
        for (int k = 0; k < 8; k++) cycle();
        check("sat_score", 32'(score_bcd), 32'h99);
        check("sat_flag", 32'(saturated), 32'd1);
        check("sat_state", 32'(state), 32'd1);

        // Fresh reset, then collision on the tick that would make 0x06.
        resetn = 1'b0;
        model_reset();
        @(negedge clkout);
        resetn = 1'b1;
        drive(1, 0, 0); cycle(); drive(0, 0, 0);
        for (int k = 0; k < 100 && !(m_score == 5 && m_cnt == TICK_DIV - 1); k++) cycle();
        check("reach_5", 32'(m_score), 32'd5);
        drive(0, 0, 1); cycle(); drive(0, 0, 0);
        check("coll_state", 32'(state), 32'd3);
        check("coll_score", 32'(score_bcd), 32'h05);
        check("coll_high", 32'(high_bcd), HE == 1 ? 32'h05 : 32'h00);
        check("coll_newhigh", 32'(new_high), 32'(HE));
        cycle();
        check("newhigh_pulse_end", 32'(new_high), 32'd0);

        // Second game ending lower keeps the old high score.
        drive(1, 0, 0); cycle(); drive(0, 0, 0);
        for (int k = 0; k < 100 && m_score != 3; k++) cycle();
        drive(0, 0, 1); cycle(); drive(0, 0, 0);
        check("g2_state", 32'(state), 32'd3);
        check("g2_high", 32'(high_bcd), HE == 1 ? 32'h05 : 32'h00);
        check("g2_newhigh", 32'(new_high), 32'd0);
        cycle();
        show_high = 1'b1;
        #1;
        check("show_high_seg0", 32'(seg[6:0]), HE == 1 ? 32'(7'b0100100) : 32'(7'b0000110));
        check("show_high_seg1", 32'(seg[13:7]), 32'(7'b0000001));
        cycle();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 39) == 0);
            show_high = 1'($urandom_range(0, 1));
            cycle();
        end

        // Asynchronous reset in the middle of a running game.
        drive(1, 0, 0); cycle(); drive(0, 0, 0);
        for (int k = 0; k < 9; k++) cycle();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_state", 32'(state), 32'd0);
        cycle();
        resetn = 1'b1;
        cycle();
        check("post_arst_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
